red_pitaya_asg_seq: RTL and testbench
=====================================

// Module: red_pitaya_asg_seq
// PURPOSE
//  Segment sequencer for one ASG channel. Holds a table of NSEG waveform segments, each
//  defined by buffer offset, size, phase step and cycle count. Programs the channel
//  config, resets and triggers it, and advances when the channel's burst ends.
//  Sits between the ASG register bank and red_pitaya_asg_ch. Drives set_ofs/size/step/
//  ncyc, set_rst and a software trigger. Observes the channel's dac_do.
// PARAMETERS
//  RSZ   14  buffer address width (matches channel); ofs/size/step are RSZ+16 bits
//  NSEG  8   segment table depth
//  SW    3   log2(NSEG), segment index width
// PORTS
//  dac_clk_i    in   1       DAC clock; single clock domain
//  dac_rst_i    in   1       synchronous, active-high reset
//  cfg_we_i     in   1       table write strobe
//  cfg_seg_i    in   SW      table entry index for write/readback
//  cfg_fld_i    in   2       field: 0=ofs 1=size 2=step 3=ncyc (LSB-aligned)
//  cfg_wdata_i  in   32      write data; truncated to field width (RSZ+16 or 16)
//  cfg_rdata_o  out  32      registered readback of [cfg_seg_i][cfg_fld_i], zero-extended
//  seq_len_i    in   SW+1    segments per pass; 0 = sequencer disabled; >NSEG clamped to NSEG
//  seq_loop_i   in   1       1 = restart at segment 0 after last, until stopped
//  seq_start_i  in   1       start pulse
//  seq_stop_i   in   1       stop pulse
//  ch_busy_i    in   1       channel burst active (dac_do)
//  set_ofs_o    out  RSZ+16  channel offset
//  set_size_o   out  RSZ+16  channel table size
//  set_step_o   out  RSZ+16  channel pointer step
//  set_ncyc_o   out  16      channel cycle count
//  set_rst_o    out  1       channel FSM reset pulse
//  trig_o       out  1       channel trigger pulse (feed trig_sw_i; src=1)
//  seq_busy_o   out  1       state != IDLE
//  seq_seg_o    out  SW      current segment index
//  seq_done_o   out  1       1-cycle pulse at end of a non-loop pass
//  seq_err_o    out  1       sticky: channel did not go busy after trigger; cleared on start
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; table contents undefined (no RAM reset).
//  Table: 1 write port plus 2 registered read ports (readback, sequencer), 1-cycle latency.
//  FSM states, one cycle each unless noted:
//   IDLE  : start & seq_len!=0 -> LOAD, seg=0, seq_err_o cleared. start with len==0 is ignored.
//   LOAD  : issue table read of seg -> LATCH.
//   LATCH : register the 4 fields onto set_*_o; ncyc==0 is driven as 1 -> RST.
//   RST   : set_rst_o=1 -> TRIG.
//   TRIG  : trig_o=1; clear wait counter -> WAITB.
//   WAITB : ch_busy_i=1 -> RUN. After 16 cycles without busy: set seq_err_o, -> NEXT.
//   RUN   : ch_busy_i=0 -> NEXT.
//   NEXT  : seg==len-1 ? (loop ? seg=0, LOAD : seq_done_o=1, IDLE) : seg+1, LOAD.
//  Timing:
//   start to trig_o: 4 cycles.
//   Busy falling edge to next trig_o: 5 cycles.
//   set_*_o are stable >=1 cycle before set_rst_o and are held through RUN.
//  Stop: seq_stop_i in any non-IDLE state -> IDLE, with set_rst_o=1 for that one cycle.
//   Stop in IDLE has no effect. Stop and start in the same cycle: stop wins.
//  start while busy: ignored.
//  Table writes during a run take effect at that entry's next LOAD. A write to the
//   active entry does not change set_*_o until its next LOAD.
//  seq_len_i is sampled at every NEXT. Lowering it below seg+1 ends the pass at the
//   next NEXT (done pulse or loop).
//  Reset mid-run: immediate IDLE, all outputs 0, no set_rst_o pulse.
// STRUCTURE
//  Package asg_seq_pkg: field codes FLD_OFS/SIZE/STEP/NCYC, state enum, WAITB_TMO=16.
//  Sub-module asg_seq_tbl: NSEG x 4-field table with 1 write and 2 registered read ports.
//  FSM, counters and output registers live in the top.
// TESTING
//  Table wr/rd: write seg3 fld2=0x12345678 -> cfg_rdata_o = masked value 1 cycle later.
//  3-seg pass: len=3, loop=0, busy model 20 cycles -> 3 rst/trig pairs, seg 0,1,2,
//   seq_done_o once, then IDLE.
//  Loop+stop: len=2, loop=1, stop during seg1 RUN -> set_rst_o pulse, busy_o=0,
//   no seq_done_o.
//  Timeout: ch_busy_i tied 0, len=1 -> trig, 16 cycles, seq_err_o=1, done pulse.
//  Corners: ncyc=0 -> set_ncyc_o=1; len=15 -> clamp to 8 segments; len=0 start ignored.
//  Simultaneous start+stop in IDLE and mid-run -> stop wins; dac_rst_i mid-RUN ->
//   all outputs 0 next cycle.

Source files
------------

// File: rtl/asg_seq_pkg.sv
`default_nettype none
// ============================================================================
// asg_seq_pkg : field codes, FSM state codes and timeout for the ASG sequencer
// Rev 1.0
// ============================================================================
package asg_seq_pkg;

  localparam logic [1:0] FLD_OFS  = 2'd0;
  localparam logic [1:0] FLD_SIZE = 2'd1;
  localparam logic [1:0] FLD_STEP = 2'd2;
  localparam logic [1:0] FLD_NCYC = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_RST   = 3'd3;
  localparam logic [2:0] ST_TRIG  = 3'd4;
  localparam logic [2:0] ST_WAITB = 3'd5;
  localparam logic [2:0] ST_RUN   = 3'd6;
  localparam logic [2:0] ST_NEXT  = 3'd7;

  localparam int unsigned WAITB_TMO = 16;

endpackage
`default_nettype wire

// File: rtl/asg_seq_tbl.sv
`default_nettype none
// ============================================================================
// asg_seq_tbl : NSEG x 4-field segment table, one write port, registered
//               readback port and registered sequencer port
// Rev 1.0
// ============================================================================
module asg_seq_tbl
  import asg_seq_pkg::*;
#(
  parameter int RSZ  = 14,
  parameter int NSEG = 8,
  parameter int SW   = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [SW-1:0]     seg_i,
  input  logic [1:0]        fld_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  input  logic [SW-1:0]     sq_seg_i,
  output logic [RSZ+15:0]   sq_ofs_o,
  output logic [RSZ+15:0]   sq_size_o,
  output logic [RSZ+15:0]   sq_step_o,
  output logic [15:0]       sq_ncyc_o
);

  localparam int W = RSZ + 16;

  logic [W-1:0]  ofs_mem  [NSEG];
  logic [W-1:0]  size_mem [NSEG];
  logic [W-1:0]  step_mem [NSEG];
  logic [15:0]   ncyc_mem [NSEG];

  logic [31:0]   rdata_d, rdata_q;
  logic [W-1:0]  sq_ofs_q, sq_size_q, sq_step_q;
  logic [15:0]   sq_ncyc_q;

  logic          unused_wdata;
  assign unused_wdata = ^wdata_i[31:W];

  // Storage has no reset; only the readback register is cleared.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      case (fld_i)
        FLD_OFS:  ofs_mem[seg_i]  <= wdata_i[W-1:0];
        FLD_SIZE: size_mem[seg_i] <= wdata_i[W-1:0];
        FLD_STEP: step_mem[seg_i] <= wdata_i[W-1:0];
        FLD_NCYC: ncyc_mem[seg_i] <= wdata_i[15:0];
      endcase
    end
    sq_ofs_q  <= ofs_mem[sq_seg_i];
    sq_size_q <= size_mem[sq_seg_i];
    sq_step_q <= step_mem[sq_seg_i];
    sq_ncyc_q <= ncyc_mem[sq_seg_i];
  end

  always_comb begin
    rdata_d = '0;
    case (fld_i)
      FLD_OFS:  rdata_d[W-1:0] = ofs_mem[seg_i];
      FLD_SIZE: rdata_d[W-1:0] = size_mem[seg_i];
      FLD_STEP: rdata_d[W-1:0] = step_mem[seg_i];
      FLD_NCYC: rdata_d[15:0]  = ncyc_mem[seg_i];
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o   = rdata_q;
  assign sq_ofs_o  = sq_ofs_q;
  assign sq_size_o = sq_size_q;
  assign sq_step_o = sq_step_q;
  assign sq_ncyc_o = sq_ncyc_q;

endmodule
`default_nettype wire

// File: rtl/red_pitaya_asg_seq.sv
`default_nettype none
// ============================================================================
// red_pitaya_asg_seq : segment sequencer that programs, resets and triggers
//                      one ASG channel per table entry
// Rev 1.0
// ============================================================================
module red_pitaya_asg_seq
  import asg_seq_pkg::*;
#(
  parameter int RSZ  = 14,
  parameter int NSEG = 8,
  parameter int SW   = 3
) (
  input  logic              dac_clk_i,
  input  logic              dac_rst_i,
  input  logic              cfg_we_i,
  input  logic [SW-1:0]     cfg_seg_i,
  input  logic [1:0]        cfg_fld_i,
  input  logic [31:0]       cfg_wdata_i,
  output logic [31:0]       cfg_rdata_o,
  input  logic [SW:0]       seq_len_i,
  input  logic              seq_loop_i,
  input  logic              seq_start_i,
  input  logic              seq_stop_i,
  input  logic              ch_busy_i,
  output logic [RSZ+15:0]   set_ofs_o,
  output logic [RSZ+15:0]   set_size_o,
  output logic [RSZ+15:0]   set_step_o,
  output logic [15:0]       set_ncyc_o,
  output logic              set_rst_o,
  output logic              trig_o,
  output logic              seq_busy_o,
  output logic [SW-1:0]     seq_seg_o,
  output logic              seq_done_o,
  output logic              seq_err_o
);

  localparam int W  = RSZ + 16;
  localparam int CW = $clog2(WAITB_TMO);

  logic [2:0]    state_q, state_d;
  logic [SW-1:0] seg_q, seg_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [W-1:0]  ofs_q, ofs_d, size_q, size_d, step_q, step_d;
  logic [15:0]   ncyc_q, ncyc_d;
  logic          rst_q, rst_d, trig_q, trig_d, done_q, done_d, err_q, err_d;
  logic          stop_rst;

  logic [W-1:0]  tbl_ofs, tbl_size, tbl_step;
  logic [15:0]   tbl_ncyc;
  logic [SW:0]   eff_len;
  logic          last_seg;

  // Sequencer read address is the next segment, so the entry's data is
  // already valid while in LOAD.
  asg_seq_tbl #(
    .RSZ  (RSZ),
    .NSEG (NSEG),
    .SW   (SW)
  ) u_tbl (
    .clk_i     (dac_clk_i),
    .rst_i     (dac_rst_i),
    .we_i      (cfg_we_i),
    .seg_i     (cfg_seg_i),
    .fld_i     (cfg_fld_i),
    .wdata_i   (cfg_wdata_i),
    .rdata_o   (cfg_rdata_o),
    .sq_seg_i  (seg_d),
    .sq_ofs_o  (tbl_ofs),
    .sq_size_o (tbl_size),
    .sq_step_o (tbl_step),
    .sq_ncyc_o (tbl_ncyc)
  );

  assign eff_len  = (seq_len_i > (SW+1)'(NSEG)) ? (SW+1)'(NSEG) : seq_len_i;
  assign last_seg = (({1'b0, seg_q} + (SW+1)'(1)) >= eff_len);

  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    wcnt_d   = wcnt_q;
    ofs_d    = ofs_q;
    size_d   = size_q;
    step_d   = step_q;
    ncyc_d   = ncyc_q;
    done_d   = 1'b0;
    err_d    = err_q;
    stop_rst = 1'b0;
    if (seq_stop_i && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      stop_rst = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (seq_start_i && !seq_stop_i && (seq_len_i != '0)) begin
            state_d = ST_LOAD;
            seg_d   = '0;
            err_d   = 1'b0;
          end
        end
        // Fields reach set_*_o as LATCH begins, a full cycle ahead of set_rst_o.
        ST_LOAD: begin
          ofs_d   = tbl_ofs;
          size_d  = tbl_size;
          step_d  = tbl_step;
          ncyc_d  = (tbl_ncyc == 16'd0) ? 16'd1 : tbl_ncyc;
          state_d = ST_LATCH;
        end
        ST_LATCH: state_d = ST_RST;
        ST_RST:   state_d = ST_TRIG;
        ST_TRIG: begin
          wcnt_d  = '0;
          state_d = ST_WAITB;
        end
        ST_WAITB: begin
          if (ch_busy_i) begin
            state_d = ST_RUN;
          end else if (wcnt_q == CW'(WAITB_TMO - 1)) begin
            err_d   = 1'b1;
            state_d = ST_NEXT;
          end else begin
            wcnt_d = wcnt_q + CW'(1);
          end
        end
        ST_RUN: begin
          if (!ch_busy_i) begin
            state_d = ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (!last_seg) begin
            seg_d   = seg_q + SW'(1);
            state_d = ST_LOAD;
          end else if (seq_loop_i) begin
            seg_d   = '0;
            state_d = ST_LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    rst_d  = stop_rst | (state_d == ST_RST);
    trig_d = (state_d == ST_TRIG);
  end

  always_ff @(posedge dac_clk_i) begin
    if (dac_rst_i) begin
      state_q <= ST_IDLE;
      seg_q   <= '0;
      wcnt_q  <= '0;
      ofs_q   <= '0;
      size_q  <= '0;
      step_q  <= '0;
      ncyc_q  <= '0;
      rst_q   <= 1'b0;
      trig_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      wcnt_q  <= wcnt_d;
      ofs_q   <= ofs_d;
      size_q  <= size_d;
      step_q  <= step_d;
      ncyc_q  <= ncyc_d;
      rst_q   <= rst_d;
      trig_q  <= trig_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign set_ofs_o  = ofs_q;
  assign set_size_o = size_q;
  assign set_step_o = step_q;
  assign set_ncyc_o = ncyc_q;
  assign set_rst_o  = rst_q;
  assign trig_o     = trig_q;
  assign seq_busy_o = (state_q != ST_IDLE);
  assign seq_seg_o  = seg_q;
  assign seq_done_o = done_q;
  assign seq_err_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_red_pitaya_asg_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_red_pitaya_asg_seq : random segment tables and channel busy profiles
//                         checked against an event-level sequencer model
// Rev 1.0
// ============================================================================
module tb_red_pitaya_asg_seq;

  localparam int RSZ  = 14;
  localparam int NSEG = 8;
  localparam int SW   = 3;
  localparam int W    = RSZ + 16;
  localparam int AW   = 32 + 3 * W + 16 + 5 + SW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, cfg_we, seq_loop, seq_start, seq_stop, ch_busy;
  logic [SW-1:0]     cfg_seg, seq_seg;
  logic [1:0]        cfg_fld;
  logic [31:0]       cfg_wdata, cfg_rdata;
  logic [SW:0]       seq_len;
  logic [W-1:0]      set_ofs, set_size, set_step;
  logic [15:0]       set_ncyc;
  logic              set_rst, trig, seq_busy, seq_done, seq_err;
  logic [AW-1:0]     all_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_tbl [NSEG][4];

  assign all_out = {cfg_rdata, set_ofs, set_size, set_step, set_ncyc,
                    set_rst, trig, seq_busy, seq_seg, seq_done, seq_err};

  red_pitaya_asg_seq #(.RSZ(RSZ), .NSEG(NSEG), .SW(SW)) dut (
    .dac_clk_i   (clk),
    .dac_rst_i   (rst),
    .cfg_we_i    (cfg_we),
    .cfg_seg_i   (cfg_seg),
    .cfg_fld_i   (cfg_fld),
    .cfg_wdata_i (cfg_wdata),
    .cfg_rdata_o (cfg_rdata),
    .seq_len_i   (seq_len),
    .seq_loop_i  (seq_loop),
    .seq_start_i (seq_start),
    .seq_stop_i  (seq_stop),
    .ch_busy_i   (ch_busy),
    .set_ofs_o   (set_ofs),
    .set_size_o  (set_size),
    .set_step_o  (set_step),
    .set_ncyc_o  (set_ncyc),
    .set_rst_o   (set_rst),
    .trig_o      (trig),
    .seq_busy_o  (seq_busy),
    .seq_seg_o   (seq_seg),
    .seq_done_o  (seq_done),
    .seq_err_o   (seq_err)
  );

  task automatic tbl_write(input int s, input int f, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_seg   = SW'(s);
    cfg_fld   = 2'(f);
    cfg_wdata = d;
    @(negedge clk);
    cfg_we = 1'b0;
    exp_tbl[s][f] = (f == 3) ? (d & 32'h0000_ffff) : (d & ((32'd1 << W) - 32'd1));
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({seq_busy, trig, set_rst, seq_done} !== 4'b0) begin
      bad++;
      $display("FAIL reset_release got=%b exp=0000", {seq_busy, trig, set_rst, seq_done});
    end
  endtask

  task automatic test_table;
    logic [31:0] d;
    tbl_write(3, 2, 32'h1234_5678);
    cfg_seg = 3'd3;
    cfg_fld = 2'd2;
    @(negedge clk);
    total++;
    if (cfg_rdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL tbl_fixed got=%h exp=%h", cfg_rdata, 32'h1234_5678);
    end
    for (int s = 0; s < NSEG; s++) begin
      for (int f = 0; f < 4; f++) begin
        d = $urandom;
        tbl_write(s, f, d);
      end
    end
    tbl_write(5, 3, 32'habcd_0000);
    for (int s = 0; s < NSEG; s++) begin
      for (int f = 0; f < 4; f++) begin
        cfg_seg = SW'(s);
        cfg_fld = 2'(f);
        @(negedge clk);
        total++;
        if (cfg_rdata !== exp_tbl[s][f]) begin
          bad++;
          $display("FAIL tbl_rb seg=%0d fld=%0d got=%h exp=%h", s, f, cfg_rdata, exp_tbl[s][f]);
        end
      end
    end
  endtask

  // Event model: trig 4 cycles after a start or NEXT decision, set_rst the
  // cycle before, NEXT one cycle after busy falls or 17 cycles after trig
  // on timeout, done one cycle after the final NEXT.
  task automatic do_run(input string name, input int len, input bit loop, input bit tmo,
                        input int stop_seg, input int stop_pass, input int exp_ntrig);
    int neff, seg, pass, t_trig, t_dec, t_done, t_stop, t_err, t_end, bs, be;
    int ntrig, ndone, exp_ndone;
    bit active, err_exp, finished;
    logic [4:0]  got_ctl, exp_ctl;
    logic [15:0] en;
    neff = (len > NSEG) ? NSEG : len;
    seg = 0; pass = 0; t_trig = 4; t_dec = -1; t_done = -1; t_stop = -10; t_err = -1;
    t_end = 0; bs = -1; be = -1; ntrig = 0; ndone = 0;
    exp_ndone = (stop_seg < 0 && !loop) ? 1 : 0;
    active = 1'b1; err_exp = 1'b0; finished = 1'b0;
    seq_len   = (SW+1)'(len);
    seq_loop  = loop;
    seq_start = 1'b1;
    for (int cyc = 1; cyc < 4000; cyc++) begin
      @(negedge clk);
      seq_start = 1'b0;
      seq_stop  = 1'b0;
      if (cyc == t_done || cyc == t_stop + 1) begin
        active = 1'b0;
        t_end  = cyc;
      end
      if (cyc == t_err) err_exp = 1'b1;
      exp_ctl = {cyc == t_trig, (cyc == t_trig - 1) || (cyc == t_stop + 1),
                 cyc == t_done, active, err_exp};
      got_ctl = {trig, set_rst, seq_done, seq_busy, seq_err};
      if (trig) ntrig++;
      if (seq_done) ndone++;
      total++;
      if (got_ctl !== exp_ctl) begin
        bad++;
        $display("FAIL %s_ctl cyc=%0d got=%b exp=%b (trig,rst,done,busy,err)", name, cyc, got_ctl, exp_ctl);
      end
      if (active && (cyc == t_trig || cyc == t_trig - 2)) begin
        en = exp_tbl[seg][3][15:0];
        if (en == 16'd0) en = 16'd1;
        total++;
        if ({set_ofs, set_size, set_step, set_ncyc, seq_seg} !==
            {exp_tbl[seg][0][W-1:0], exp_tbl[seg][1][W-1:0], exp_tbl[seg][2][W-1:0], en, SW'(seg)}) begin
          bad++;
          $display("FAIL %s_fields cyc=%0d seg=%0d got=%h/%h/%h/%h/%0d exp=%h/%h/%h/%h/%0d", name, cyc, seg,
                   set_ofs, set_size, set_step, set_ncyc, seq_seg,
                   exp_tbl[seg][0][W-1:0], exp_tbl[seg][1][W-1:0], exp_tbl[seg][2][W-1:0], en, seg);
        end
      end
      if (cyc == t_trig) begin
        if (tmo) begin
          bs = -1; be = -1; t_dec = cyc + 17;
          if (t_err < 0) t_err = cyc + 17;
        end else begin
          bs = cyc + int'($urandom_range(1, 6));
          be = bs + int'($urandom_range(2, 25));
          t_dec = be + 1;
          if (seg == stop_seg && pass == stop_pass) begin
            t_stop = be - 1;
            t_dec  = -1;
          end
        end
      end
      if (cyc == t_dec) begin
        if (seg + 1 >= neff) begin
          if (loop) begin
            seg = 0; pass++; t_trig = cyc + 4;
          end else begin
            t_done = cyc + 1;
          end
        end else begin
          seg++; t_trig = cyc + 4;
        end
      end
      ch_busy   = (cyc >= bs) && (cyc < be);
      seq_stop  = (cyc == t_stop);
      seq_start = (cyc == t_stop) || (cyc == t_trig + 1);
      if (!active && cyc >= t_end + 3) begin
        finished = 1'b1;
        break;
      end
    end
    seq_start = 1'b0;
    seq_stop  = 1'b0;
    ch_busy   = 1'b0;
    total++;
    if (!finished) begin
      bad++;
      $display("FAIL %s_timeout got=running exp=finished", name);
    end
    total++;
    if (ntrig != exp_ntrig || ndone != exp_ndone) begin
      bad++;
      $display("FAIL %s_counts got=trig%0d/done%0d exp=trig%0d/done%0d", name, ntrig, ndone, exp_ntrig, exp_ndone);
    end
  endtask

  task automatic test_idle_ignored(input string name, input int len, input bit stop);
    seq_len   = (SW+1)'(len);
    seq_loop  = 1'b0;
    seq_start = 1'b1;
    seq_stop  = stop;
    @(negedge clk);
    seq_start = 1'b0;
    seq_stop  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({seq_busy, trig, set_rst, seq_done} !== 4'b0) begin
        bad++;
        $display("FAIL %s cyc=%0d got=%b exp=0000", name, i, {seq_busy, trig, set_rst, seq_done});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midrun;
    seq_len   = 4'd2;
    seq_loop  = 1'b1;
    seq_start = 1'b1;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      seq_start = 1'b0;
      ch_busy   = 1'b1;
    end
    total++;
    if (seq_busy !== 1'b1 || set_ofs !== exp_tbl[0][0][W-1:0]) begin
      bad++;
      $display("FAIL midrun_before got=%b/%h exp=1/%h", seq_busy, set_ofs, exp_tbl[0][0][W-1:0]);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (all_out !== '0) begin
      bad++;
      $display("FAIL midrun_reset got=%h exp=0", all_out);
    end
    rst     = 1'b0;
    ch_busy = 1'b0;
    @(negedge clk);
    total++;
    if ({seq_busy, trig, set_rst} !== 3'b0) begin
      bad++;
      $display("FAIL midrun_after got=%b exp=000", {seq_busy, trig, set_rst});
    end
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_seg = '0; cfg_fld = '0; cfg_wdata = '0;
    seq_len = '0; seq_loop = 1'b0; seq_start = 1'b0; seq_stop = 1'b0; ch_busy = 1'b0;
    @(negedge clk);
    test_reset;
    test_table;
    do_run("pass3", 3, 1'b0, 1'b0, -1, -1, 3);
    do_run("loopstop", 2, 1'b1, 1'b0, 1, 1, 4);
    do_run("timeout", 1, 1'b0, 1'b1, -1, -1, 1);
    do_run("clamp", 15, 1'b0, 1'b0, -1, -1, 8);
    test_idle_ignored("len0_start", 0, 1'b0);
    test_idle_ignored("idle_start_stop", 3, 1'b1);
    test_reset_midrun;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
